// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_sequencer
// Description : Sequences every MEM-stage data access of the MIPS32 core.
//               It issues one read or write to the data memory port and
//               stalls the pipeline until memory acknowledges. It latches the
//               sub-word, unaligned and atomic controls for the read-data
//               manipulator. It buffers returned data while another source
//               holds the pipeline, and it owns the LL/SC reservation.
// Ports       : clock/reset      - core clock, async active-low reset
//               M_*              - MEM-stage request, controls and store data
//               Eret, Snoop_*    - reservation clear sources
//               DataMem_*        - data memory port (registered strobes)
//               M_Stall          - stall request to the pipeline
//               RDC_*            - latched controls and data for the
//                                  read-data manipulator
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_Read,
  input  logic        M_Write,
  input  logic [31:0] M_Address,
  input  logic        M_Byte,
  input  logic        M_Half,
  input  logic        M_SignExtend,
  input  logic        M_Left,
  input  logic        M_Right,
  input  logic        M_LL,
  input  logic        M_SC,
  input  logic [3:0]  M_WriteEnable,
  input  logic [31:0] M_WriteData,
  input  logic        M_Flush,
  input  logic        M_Stall_Ext,
  input  logic        Eret,
  input  logic        Snoop_Write,
  input  logic [29:0] Snoop_Address,
  input  logic        DataMem_Ready,
  input  logic [31:0] DataMem_ReadData,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_WriteData,
  output logic        M_Stall,
  output logic [1:0]  RDC_Address,
  output logic        RDC_Byte,
  output logic        RDC_Half,
  output logic        RDC_SignExtend,
  output logic        RDC_Left,
  output logic        RDC_Right,
  output logic        RDC_SC,
  output logic        RDC_Atomic,
  output logic [31:0] RDC_ReadData
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_dm_read;
  logic [3:0]  r_dm_we;
  logic [29:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [1:0]  r_rdc_addr;
  logic        r_rdc_byte, r_rdc_half, r_rdc_sext, r_rdc_left, r_rdc_right;
  logic        r_rdc_sc, r_rdc_atomic;
  logic        r_ll;
  logic        r_killed;
  logic [31:0] r_buf;
  logic        r_llbit;
  logic [29:0] r_lladdr;

  logic w_idle, w_wait, w_req_ok, w_sc_fail, w_issue, w_sc_fail_idle;
  logic w_killed, w_ack, w_ll_set, w_sc_clr, w_snoop_hit;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wait   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_req_ok = w_idle & (M_Read | M_Write) & ~M_Flush;
  // An SC without a live reservation is resolved locally, never reaching memory.
  assign w_sc_fail      = M_Write & M_SC & ~r_llbit;
  assign w_issue        = w_req_ok & ~w_sc_fail;
  assign w_sc_fail_idle = w_req_ok & w_sc_fail;

  // A flush arriving in the acknowledge cycle kills the access as well.
  assign w_killed    = r_killed | M_Flush;
  assign w_ack       = w_wait & DataMem_Ready;
  assign w_ll_set    = w_ack & ~w_killed & r_ll;
  assign w_sc_clr    = (w_ack & ~w_killed & r_rdc_sc) | w_sc_fail_idle;
  assign w_snoop_hit = Snoop_Write & (Snoop_Address == r_lladdr);

  // A killed access keeps the pipeline held through its acknowledge so the
  // flushed instruction never observes a completion.
  assign M_Stall      = w_issue | (w_wait & (~DataMem_Ready | w_killed));
  assign RDC_ReadData = w_ack ? DataMem_ReadData : r_buf;

  assign DataMem_Read      = r_dm_read;
  assign DataMem_Write     = r_dm_we;
  assign DataMem_Address   = r_dm_addr;
  assign DataMem_WriteData = r_dm_wdata;
  assign RDC_Address       = r_rdc_addr;
  assign RDC_Byte          = r_rdc_byte;
  assign RDC_Half          = r_rdc_half;
  assign RDC_SignExtend    = r_rdc_sext;
  assign RDC_Left          = r_rdc_left;
  assign RDC_Right         = r_rdc_right;
  assign RDC_SC            = r_rdc_sc;
  assign RDC_Atomic        = r_rdc_atomic;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_dm_read    <= 1'b0;
      r_dm_we      <= 4'h0;
      r_dm_addr    <= 30'h0;
      r_dm_wdata   <= 32'h0;
      r_rdc_addr   <= 2'b00;
      r_rdc_byte   <= 1'b0;
      r_rdc_half   <= 1'b0;
      r_rdc_sext   <= 1'b0;
      r_rdc_left   <= 1'b0;
      r_rdc_right  <= 1'b0;
      r_rdc_sc     <= 1'b0;
      r_rdc_atomic <= 1'b0;
      r_ll         <= 1'b0;
      r_killed     <= 1'b0;
      r_buf        <= 32'h0;
      r_llbit      <= 1'b0;
      r_lladdr     <= 30'h0;
    end else begin
      // Reservation: Eret, then LL completion, then snoop, then SC completion.
      if (Eret) begin
        r_llbit <= 1'b0;
      end else if (w_ll_set) begin
        r_llbit  <= 1'b1;
        r_lladdr <= r_dm_addr;
      end else if (w_snoop_hit || w_sc_clr) begin
        r_llbit <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_dm_read    <= M_Read;
            r_dm_we      <= M_Write ? M_WriteEnable : 4'h0;
            r_dm_addr    <= M_Address[31:2];
            r_dm_wdata   <= M_WriteData;
            r_rdc_addr   <= M_Address[1:0];
            r_rdc_byte   <= M_Byte;
            r_rdc_half   <= M_Half;
            r_rdc_sext   <= M_SignExtend;
            r_rdc_left   <= M_Left;
            r_rdc_right  <= M_Right;
            r_rdc_sc     <= M_SC;
            r_rdc_atomic <= M_SC & r_llbit;
            r_ll         <= M_LL & M_Read;
            r_killed     <= 1'b0;
            r_state      <= M_Read ? S_RD_WAIT : S_WR_WAIT;
          end else if (w_sc_fail_idle) begin
            r_rdc_sc     <= 1'b1;
            r_rdc_atomic <= 1'b0;
            if (M_Stall_Ext) r_state <= S_DONE;
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (M_Flush) r_killed <= 1'b1;
          if (DataMem_Ready) begin
            r_dm_read <= 1'b0;
            r_dm_we   <= 4'h0;
            r_buf     <= DataMem_ReadData;
            r_state   <= (!w_killed && M_Stall_Ext) ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (!M_Stall_Ext) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Directed self-checking bench for mem_access_sequencer.
//               Inputs change 1 ns after the rising edge and outputs are
//               sampled 3 ns after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        M_Read = 1'b0, M_Write = 1'b0;
  logic [31:0] M_Address = 32'h0;
  logic        M_Byte = 1'b0, M_Half = 1'b0, M_SignExtend = 1'b0;
  logic        M_Left = 1'b0, M_Right = 1'b0, M_LL = 1'b0, M_SC = 1'b0;
  logic [3:0]  M_WriteEnable = 4'h0;
  logic [31:0] M_WriteData = 32'h0;
  logic        M_Flush = 1'b0, M_Stall_Ext = 1'b0, Eret = 1'b0;
  logic        Snoop_Write = 1'b0;
  logic [29:0] Snoop_Address = 30'h0;
  logic        DataMem_Ready = 1'b0;
  logic [31:0] DataMem_ReadData = 32'h0;

  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_WriteData;
  logic        M_Stall;
  logic [1:0]  RDC_Address;
  logic        RDC_Byte, RDC_Half, RDC_SignExtend, RDC_Left, RDC_Right;
  logic        RDC_SC, RDC_Atomic;
  logic [31:0] RDC_ReadData;

  int checks   = 0;
  int failures = 0;

  mem_access_sequencer dut (
    .clock(clock), .reset(reset),
    .M_Read(M_Read), .M_Write(M_Write), .M_Address(M_Address),
    .M_Byte(M_Byte), .M_Half(M_Half), .M_SignExtend(M_SignExtend),
    .M_Left(M_Left), .M_Right(M_Right), .M_LL(M_LL), .M_SC(M_SC),
    .M_WriteEnable(M_WriteEnable), .M_WriteData(M_WriteData),
    .M_Flush(M_Flush), .M_Stall_Ext(M_Stall_Ext), .Eret(Eret),
    .Snoop_Write(Snoop_Write), .Snoop_Address(Snoop_Address),
    .DataMem_Ready(DataMem_Ready), .DataMem_ReadData(DataMem_ReadData),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .DataMem_WriteData(DataMem_WriteData),
    .M_Stall(M_Stall), .RDC_Address(RDC_Address),
    .RDC_Byte(RDC_Byte), .RDC_Half(RDC_Half), .RDC_SignExtend(RDC_SignExtend),
    .RDC_Left(RDC_Left), .RDC_Right(RDC_Right), .RDC_SC(RDC_SC),
    .RDC_Atomic(RDC_Atomic), .RDC_ReadData(RDC_ReadData)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_req();
    M_Read = 1'b0; M_Write = 1'b0; M_Address = 32'h0;
    M_Byte = 1'b0; M_Half = 1'b0; M_SignExtend = 1'b0;
    M_Left = 1'b0; M_Right = 1'b0; M_LL = 1'b0; M_SC = 1'b0;
    M_WriteEnable = 4'h0; M_WriteData = 32'h0;
    M_Flush = 1'b0; M_Stall_Ext = 1'b0; Eret = 1'b0;
    Snoop_Write = 1'b0; Snoop_Address = 30'h0;
    DataMem_Ready = 1'b0; DataMem_ReadData = 32'h0;
  endtask

  // Zero-wait LL: issue cycle, then acknowledge in cycle 1.
  task automatic do_ll(input logic [31:0] addr, input logic eret_at_ack);
    tick(); clear_req(); M_Read = 1'b1; M_LL = 1'b1; M_Address = addr;
    settle(); chk("ll_issue_stall", 32'(M_Stall), 1);
    tick(); DataMem_Ready = 1'b1; Eret = eret_at_ack;
    settle(); chk("ll_ack_stall", 32'(M_Stall), 0);
    tick(); clear_req();
  endtask

  // SC expected to fail: no stall in the issue cycle, no write afterwards.
  task automatic sc_expect_fail(input logic [31:0] addr, input string tag);
    clear_req(); M_Write = 1'b1; M_SC = 1'b1; M_Address = addr;
    M_WriteEnable = 4'hF; M_WriteData = 32'h1;
    settle(); chk({tag, "_stall"}, 32'(M_Stall), 0);
    tick(); clear_req();
    settle();
    chk({tag, "_nowrite"}, 32'(DataMem_Write), 0);
    chk({tag, "_atomic"}, 32'(RDC_Atomic), 0);
    chk({tag, "_rdcsc"}, 32'(RDC_SC), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst_read", 32'(DataMem_Read), 0);
    chk("rst_write", 32'(DataMem_Write), 0);
    chk("rst_addr", 32'(DataMem_Address), 0);
    chk("rst_wdata", DataMem_WriteData, 0);
    chk("rst_stall", 32'(M_Stall), 0);
    chk("rst_rdata", RDC_ReadData, 0);
    chk("rst_rdc", {RDC_Address, RDC_Byte, RDC_Half, RDC_SignExtend,
                    RDC_Left, RDC_Right, RDC_SC, RDC_Atomic}, 0);
    #10 reset = 1'b1;

    // ---------------- zero-wait LB ----------------
    tick(); M_Read = 1'b1; M_Address = 32'h1003; M_Byte = 1'b1; M_SignExtend = 1'b1;
    settle();
    chk("lb_c0_stall", 32'(M_Stall), 1);
    chk("lb_c0_read", 32'(DataMem_Read), 0);
    tick(); DataMem_Ready = 1'b1; DataMem_ReadData = 32'h000000F0;
    settle();
    chk("lb_c1_read", 32'(DataMem_Read), 1);
    chk("lb_c1_addr", 32'(DataMem_Address), 32'h400);
    chk("lb_c1_rdcaddr", 32'(RDC_Address), 3);
    chk("lb_c1_ctl", {RDC_Byte, RDC_Half, RDC_SignExtend}, 32'b101);
    chk("lb_c1_stall", 32'(M_Stall), 0);
    chk("lb_c1_rdata", RDC_ReadData, 32'h000000F0);
    tick(); clear_req();
    settle();
    chk("lb_c2_read", 32'(DataMem_Read), 0);
    chk("lb_c2_rdata", RDC_ReadData, 32'h000000F0);

    // ---------------- 3-wait SW ----------------
    tick(); M_Write = 1'b1; M_Address = 32'h0000_0100;
    M_WriteEnable = 4'hF; M_WriteData = 32'hDEADBEEF;
    settle(); chk("sw_c0_stall", 32'(M_Stall), 1);
    for (int c = 1; c <= 3; c++) begin
      tick(); settle();
      chk("sw_wait_we", 32'(DataMem_Write), 32'hF);
      chk("sw_wait_stall", 32'(M_Stall), 1);
    end
    tick(); DataMem_Ready = 1'b1;
    settle();
    chk("sw_ack_we", 32'(DataMem_Write), 32'hF);
    chk("sw_ack_wdata", DataMem_WriteData, 32'hDEADBEEF);
    chk("sw_ack_addr", 32'(DataMem_Address), 32'h40);
    chk("sw_ack_stall", 32'(M_Stall), 0);
    tick(); clear_req();
    settle(); chk("sw_after_we", 32'(DataMem_Write), 0);

    // ---------------- LL then successful SC ----------------
    do_ll(32'h2000, 1'b0);
    M_Write = 1'b1; M_SC = 1'b1; M_Address = 32'h2000;
    M_WriteEnable = 4'hF; M_WriteData = 32'h0000_0055;
    settle(); chk("sc_ok_stall", 32'(M_Stall), 1);
    tick(); DataMem_Ready = 1'b1;
    settle();
    chk("sc_ok_we", 32'(DataMem_Write), 32'hF);
    chk("sc_ok_atomic", 32'(RDC_Atomic), 1);
    chk("sc_ok_rdcsc", 32'(RDC_SC), 1);
    tick(); clear_req();
    settle(); chk("sc_ok_after_we", 32'(DataMem_Write), 0);
    // Reservation consumed by the SC: a second SC must fail.
    sc_expect_fail(32'h2000, "sc_again");

    // ---------------- LL, matching snoop, SC fails ----------------
    do_ll(32'h2000, 1'b0);
    Snoop_Write = 1'b1; Snoop_Address = 30'h800;
    tick(); clear_req();
    sc_expect_fail(32'h2000, "sc_snoop");

    // ---------------- LL, non-matching snoop, SC succeeds ----------------
    do_ll(32'h2000, 1'b0);
    Snoop_Write = 1'b1; Snoop_Address = 30'h801;
    tick(); clear_req();
    M_Write = 1'b1; M_SC = 1'b1; M_Address = 32'h2000; M_WriteEnable = 4'hF;
    settle(); chk("sc_miss_stall", 32'(M_Stall), 1);
    tick(); DataMem_Ready = 1'b1;
    settle(); chk("sc_miss_atomic", 32'(RDC_Atomic), 1);
    tick(); clear_req();

    // ---------------- ready with external stall -> DONE ----------------
    M_Read = 1'b1; M_Address = 32'h3000;
    settle(); chk("ext_c0_stall", 32'(M_Stall), 1);
    tick(); DataMem_Ready = 1'b1; DataMem_ReadData = 32'h12345678; M_Stall_Ext = 1'b1;
    settle();
    chk("ext_c1_rdata", RDC_ReadData, 32'h12345678);
    chk("ext_c1_stall", 32'(M_Stall), 0);
    tick(); DataMem_Ready = 1'b0; DataMem_ReadData = 32'hBAD0BAD0;
    settle();
    chk("ext_c2_read", 32'(DataMem_Read), 0);
    chk("ext_c2_rdata", RDC_ReadData, 32'h12345678);
    chk("ext_c2_stall", 32'(M_Stall), 0);
    tick(); M_Stall_Ext = 1'b0;
    settle();
    chk("ext_c3_read", 32'(DataMem_Read), 0);
    chk("ext_c3_rdata", RDC_ReadData, 32'h12345678);
    chk("ext_c3_stall", 32'(M_Stall), 0);
    tick(); clear_req();
    settle(); chk("ext_c4_read", 32'(DataMem_Read), 0);

    // ---------------- flush during a 2-wait LL ----------------
    M_Read = 1'b1; M_LL = 1'b1; M_Address = 32'h4000;
    settle(); chk("fl_c0_stall", 32'(M_Stall), 1);
    tick(); M_Flush = 1'b1;
    settle();
    chk("fl_c1_read", 32'(DataMem_Read), 1);
    chk("fl_c1_stall", 32'(M_Stall), 1);
    tick(); M_Flush = 1'b0;
    settle(); chk("fl_c2_stall", 32'(M_Stall), 1);
    tick(); DataMem_Ready = 1'b1;
    settle();
    chk("fl_c3_read", 32'(DataMem_Read), 1);
    chk("fl_c3_stall", 32'(M_Stall), 1);
    tick(); clear_req();
    settle();
    chk("fl_c4_read", 32'(DataMem_Read), 0);
    chk("fl_c4_stall", 32'(M_Stall), 0);
    sc_expect_fail(32'h4000, "sc_flush");

    // ---------------- Eret concurrent with LL completion ----------------
    do_ll(32'h5000, 1'b1);
    sc_expect_fail(32'h5000, "sc_eret");

    // ---------------- reset during RD_WAIT ----------------
    do_ll(32'h6000, 1'b0);
    M_Read = 1'b1; M_Address = 32'h7002;
    tick();
    settle();
    chk("rst_mid_read_pre", 32'(DataMem_Read), 1);
    chk("rst_mid_rdcaddr_pre", 32'(RDC_Address), 2);
    M_Read = 1'b0; reset = 1'b0;
    #1;
    chk("rst_mid_read", 32'(DataMem_Read), 0);
    chk("rst_mid_stall", 32'(M_Stall), 0);
    chk("rst_mid_rdcaddr", 32'(RDC_Address), 0);
    tick(); reset = 1'b1;
    tick();
    sc_expect_fail(32'h6000, "sc_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences every MEM-stage data access of the MIPS32 core. It issues read and write transactions to the data memory port and stalls the pipeline until memory acknowledges. It holds the sub-word, unaligned and atomic control fields stable for the read-data manipulator, and buffers returned data when the pipeline is held by another stall source. It also owns the LL/SC reservation (LLbit and reserved word address).

## Interface
- No parameters.
- clock  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- M_Read  in  1  MEM-stage load request (level).
- M_Write  in  1  MEM-stage store request (level); exclusive with M_Read.
- M_Address  in  32  access byte address.
- M_Byte, M_Half, M_SignExtend, M_Left, M_Right  in  1 each  sub-word/unaligned load controls.
- M_LL  in  1  load is LL. M_SC  in  1  store is SC.
- M_WriteEnable  in  4  store byte enables (already endian-adjusted).
- M_WriteData  in  32  store data.
- M_Flush  in  1  MEM-stage instruction is being killed.
- M_Stall_Ext  in  1  pipeline held by another source this cycle.
- Eret  in  1  clears the reservation.
- Snoop_Write  in  1  external write observed.
- Snoop_Address  in  30  word address of that write.
- DataMem_Ready  in  1  memory acknowledge.
- DataMem_ReadData  in  32  memory read data.
- DataMem_Read  out  1  read strobe.
- DataMem_Write  out  4  registered byte write enables.
- DataMem_Address  out  30  registered word address.
- DataMem_WriteData  out  32  registered store data.
- M_Stall  out  1  stall request to the pipeline.
- RDC_Address  out  2  latched Address[1:0] for the read manipulator.
- RDC_Byte, RDC_Half, RDC_SignExtend, RDC_Left, RDC_Right, RDC_SC  out  1 each  latched controls.
- RDC_Atomic  out  1  SC success flag.
- RDC_ReadData  out  32  data to the manipulator.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, request present (M_Read or M_Write) and ~M_Flush:
  - Latch address, controls and write data.
  - Latch RDC_Atomic = LLbit when M_SC.
  - Go to RD_WAIT on a read, or to WR_WAIT on a write.
- SC with LLbit=0 from IDLE: no memory transaction. Latch RDC_SC=1 and RDC_Atomic=0, then go to DONE if M_Stall_Ext, else stay in IDLE.
- M_Flush in IDLE: no issue, no latch.
- RD_WAIT: DataMem_Read=1.
- WR_WAIT: DataMem_Write = latched enables.
- DataMem_Ready is sampled only in RD_WAIT or WR_WAIT. On Ready:
  - strobes drop next cycle;
  - go to IDLE, or to DONE if M_Stall_Ext;
  - capture DataMem_ReadData into the 32-bit buffer.
- DONE: M_Stall=0, no reissue. Return to IDLE on the first cycle with ~M_Stall_Ext.
- RDC_ReadData = DataMem_ReadData in the Ready cycle; buffer in DONE; otherwise buffer.
- Flush while in RD_WAIT or WR_WAIT: the access is marked killed. The transaction still completes (a bus access is not abandoned). On Ready go to IDLE with no LLbit effect and no DONE.
- Reservation updates, per cycle, in priority order:
  1. Eret clears LLbit.
  2. Completing non-killed LL sets LLbit=1 and LLAddr=address[31:2].
  3. Snoop_Write with Snoop_Address==LLAddr clears LLbit.
  4. Completing SC (success or fail) clears LLbit.
- M_Stall (combinational) = 1 when any of:
  - IDLE with an issuing request;
  - RD_WAIT or WR_WAIT with ~DataMem_Ready;
  - RD_WAIT or WR_WAIT with a killed access.
- M_Stall = 0 otherwise, including IDLE with a failing SC.

## Timing
- Reset (asynchronous, active-low):
  - state IDLE;
  - DataMem_Read=0, DataMem_Write=0, DataMem_Address=0, DataMem_WriteData=0;
  - all RDC_* = 0, buffer=0;
  - LLbit=0, LLAddr=0;
  - M_Stall follows its equation (0 with no request).
- Reset mid-transaction aborts immediately. The memory side must tolerate strobe drop.
- Cycle 0: request seen in IDLE, M_Stall=1.
- Cycle 1: strobe asserted.
- Ready in cycle 1 releases the stall that cycle. Minimum load latency is 2 cycles, plus 1 per memory wait cycle.
- RDC_* fields are constant from cycle 1 until the next issue.
- Back-to-back accesses: the next request issues the cycle after return to IDLE.

## Test plan
- Zero-wait LB: Address 0x1003, SignExtend=1, mem 0x000000F0, Ready in cycle 1 -> M_Stall 1,0. DataMem_Address=0x400. RDC_Address=3. RDC_ReadData=0x000000F0 in cycle 1.
- 3-wait SW, M_WriteEnable=0xF, data 0xDEADBEEF -> DataMem_Write=0xF for 4 cycles, M_Stall high 4 cycles, strobe 0 after Ready.
- LL to 0x2000, then SC to 0x2000 with no snoop -> SC writes, RDC_Atomic=1, LLbit=0 after. Repeat with Snoop_Write to 0x800 between -> SC issues no write, RDC_Atomic=0, M_Stall never asserted.
- Ready concurrent with M_Stall_Ext=1 for 2 cycles, data 0x12345678 -> DONE holds, RDC_ReadData=0x12345678 throughout, no second DataMem_Read.
- M_Flush in cycle 1 of a 2-wait LL -> stall until Ready, LLbit stays 0. Eret concurrent with LL completion -> LLbit=0.
- reset low during RD_WAIT -> DataMem_Read=0 immediately, state IDLE, LLbit=0.
